ud_counter_ctrl: RTL and testbench

Run controller that drives the control side of the lab's up/down loadable BCD/hex counter: it generates the `enable` step tick, `load`/`load_count`, `updown` and `mode`, and consumes the counter's `done` flag. It sits between the board buttons/switches and the counter. It provides:
- run/pause/halt sequencing
- a prescaled step rate
- stop-at-limit or bounce (reverse direction at limit) behaviour

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/sync_edge.sv | 27 ++
 rtl/ud_counter_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ud_counter_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the up/down counter run controller.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A BCD counter cannot hold a digit above 9, so loads are clamped there.
  function automatic logic [3:0] clamp_load(input logic bcd, input logic [3:0] value);
    return (bcd && (value > BCD_MAX)) ? BCD_MAX : value;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a single-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/ud_counter_ctrl.sv
// Run controller for the up/down loadable counter: button-driven run/pause/halt
// sequencing, prescaled step ticks, and stop-or-bounce handling at the count limit.
module ud_counter_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PW       = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic       sw_dir,
  input  logic       sw_mode,
  input  logic       sw_bounce,
  input  logic [3:0] sw_value,
  input  logic       done,
  output logic       enable,
  output logic       updown,
  output logic       mode,
  output logic       load,
  output logic [3:0] load_count,
  output logic [1:0] state_out
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic            r_enable;
  logic            w_enable_nxt;
  logic            r_load;
  logic            w_load_nxt;
  logic [3:0]      r_load_count;
  logic [3:0]      w_load_count_nxt;
  logic            r_updown;
  logic            w_updown_nxt;
  logic            r_mode;
  logic            w_mode_nxt;
  logic            w_start_e;
  logic            w_load_e;
  logic            w_wrap;

  sync_edge u_sync_start (
    .clk   (clk),
    .reset (reset),
    .din   (btn_start),
    .rise  (w_start_e)
  );

  sync_edge u_sync_load (
    .clk   (clk),
    .reset (reset),
    .din   (btn_load),
    .rise  (w_load_e)
  );

  assign w_wrap = (r_presc == PRESC_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; in PAUSE a load edge takes priority over resume
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_load_e && w_start_e) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_start_e) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_wrap && done && !sw_bounce) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_PAUSE: begin
        if (!w_load_e && w_start_e) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (w_load_e) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; switches track freely outside RUN
  always_comb begin
    w_enable_nxt     = 1'b0;
    w_load_nxt       = 1'b0;
    w_load_count_nxt = r_load_count;
    w_updown_nxt     = r_updown;
    w_mode_nxt       = r_mode;
    w_presc_nxt      = r_presc;

    if (r_state != ST_RUN) begin
      w_updown_nxt = sw_dir;
      w_mode_nxt   = sw_mode;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_load_e) begin
          w_load_nxt       = 1'b1;
          w_load_count_nxt = clamp_load(sw_mode, sw_value);
        end else if (w_start_e) begin
          w_presc_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!w_start_e) begin
          w_presc_nxt = w_wrap ? '0 : (r_presc + PW'(1));
          if (w_wrap) begin
            if (!done) begin
              w_enable_nxt = 1'b1;
            end else if (sw_bounce) begin
              w_updown_nxt = ~r_updown;
              w_enable_nxt = 1'b1;
            end
          end
        end
      end
      ST_PAUSE, ST_HALT: begin
        if (w_load_e) begin
          w_load_nxt       = 1'b1;
          w_load_count_nxt = clamp_load(sw_mode, sw_value);
        end
      end
      default: begin
        w_presc_nxt = '0;
      end
    endcase
  end

  // Output and prescaler registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc      <= '0;
      r_enable     <= 1'b0;
      r_load       <= 1'b0;
      r_load_count <= 4'd0;
      r_updown     <= 1'b1;
      r_mode       <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_enable     <= w_enable_nxt;
      r_load       <= w_load_nxt;
      r_load_count <= w_load_count_nxt;
      r_updown     <= w_updown_nxt;
      r_mode       <= w_mode_nxt;
    end
  end

  assign enable     = r_enable;
  assign load       = r_load;
  assign load_count = r_load_count;
  assign updown     = r_updown;
  assign mode       = r_mode;
  assign state_out  = r_state;

endmodule

// File: tb/tb_ud_counter_ctrl.sv
// Bench for ud_counter_ctrl: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the controller.
module tb_ud_counter_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       btn_load;
  logic       sw_dir;
  logic       sw_mode;
  logic       sw_bounce;
  logic [3:0] sw_value;
  logic       done;
  logic       enable;
  logic       updown;
  logic       mode;
  logic       load;
  logic [3:0] load_count;
  logic [1:0] state_out;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: 0=IDLE 1=RUN 2=PAUSE 3=HALT
  int         m_st;
  int         m_cnt;
  logic       m_en;
  logic       m_ld;
  logic       m_upd;
  logic       m_md;
  logic [3:0] m_lc;
  logic [2:0] hs;
  logic [2:0] hl;

  ud_counter_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_load   (btn_load),
    .sw_dir     (sw_dir),
    .sw_mode    (sw_mode),
    .sw_bounce  (sw_bounce),
    .sw_value   (sw_value),
    .done       (done),
    .enable     (enable),
    .updown     (updown),
    .mode       (mode),
    .load       (load),
    .load_count (load_count),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_en = 1'b0; m_ld = 1'b0;
    m_upd = 1'b1; m_md = 1'b0; m_lc = 4'd0;
    hs = 3'b000; hl = 3'b000;
  endtask

  task automatic model_strobe();
    m_ld = 1'b1;
    m_lc = (sw_mode && (sw_value > 4'd9)) ? 4'd9 : sw_value;
  endtask

  // One clock edge of the reference: a button sampled high two edges ago
  // after being low three edges ago counts as a press now.
  task automatic model_edge();
    logic se;
    logic le;
    se = hs[1] & ~hs[2];
    le = hl[1] & ~hl[2];
    m_en = 1'b0;
    m_ld = 1'b0;
    if (m_st != 1) begin
      m_upd = sw_dir;
      m_md  = sw_mode;
    end
    if (m_st == 0) begin
      if (le) model_strobe();
      else if (se) begin m_st = 1; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (se) m_st = 2;
      else begin
        if (m_cnt == TD - 1) begin
          if (!done) m_en = 1'b1;
          else if (sw_bounce) begin m_upd = !m_upd; m_en = 1'b1; end
          else m_st = 3;
        end
        m_cnt = (m_cnt + 1) % TD;
      end
    end else if (m_st == 2) begin
      if (le) model_strobe();
      else if (se) m_st = 1;
    end else begin
      if (le) begin model_strobe(); m_st = 0; end
    end
    hs = {hs[1:0], btn_start};
    hl = {hl[1:0], btn_load};
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".enable"}, 4'(enable), 4'(m_en));
    chk({ph, ".load"}, 4'(load), 4'(m_ld));
    chk({ph, ".load_count"}, load_count, m_lc);
    chk({ph, ".updown"}, 4'(updown), 4'(m_upd));
    chk({ph, ".mode"}, 4'(mode), 4'(m_md));
    chk({ph, ".state"}, 4'(state_out), 4'(m_st));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic press_start(input string ph);
    btn_start = 1'b1; tick(ph);
    btn_start = 1'b0; tick(ph);
  endtask

  task automatic press_load(input string ph);
    btn_load = 1'b1; tick(ph);
    btn_load = 1'b0; tick(ph);
  endtask

  // Mid-cycle asynchronous reset pulse, released before the next edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    #3;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_load = 1'b0;
    sw_dir = 1'b1; sw_mode = 1'b0; sw_bounce = 1'b0; sw_value = 4'd0; done = 1'b0;
    model_reset();
    #2;
    chk("por.enable", 4'(enable), 4'd0);
    chk("por.updown", 4'(updown), 4'd1);
    chk("por.state", 4'(state_out), 4'd0);
    check_all("por");
    #1 reset = 1'b0;

    // Load clamp in BCD and unclamped in hex
    tick("idle");
    sw_mode = 1'b1; sw_value = 4'hC;
    press_load("ld_bcd");
    tick("ld_bcd");
    chk("ld_bcd.load", 4'(load), 4'd1);
    chk("ld_bcd.count", load_count, 4'd9);
    chk("ld_bcd.state", 4'(state_out), 4'd0);
    tick("ld_bcd");
    chk("ld_bcd.load_off", 4'(load), 4'd0);
    sw_mode = 1'b0;
    press_load("ld_hex");
    tick("ld_hex");
    chk("ld_hex.load", 4'(load), 4'd1);
    chk("ld_hex.count", load_count, 4'hC);
    tick("ld_hex");
    chk("ld_hex.load_off", 4'(load), 4'd0);

    // Run cadence with direction frozen; a pause press is queued near the end
    sw_dir = 1'b0;
    press_start("run");
    tick("run");
    chk("run.state", 4'(state_out), 4'd1);
    chk("run.updown", 4'(updown), 4'd0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 5) sw_dir = 1'b1;
      tick("cad");
      chk("cad.enable", 4'(enable), 4'((i % 4) == 0));
      chk("cad.updown", 4'(updown), 4'd0);
      if (i == 11) btn_start = 1'b1;
      if (i == 12) btn_start = 1'b0;
    end
    tick("cad");
    chk("cad.prepause", 4'(state_out), 4'd1);

    // Pause with prescaler held at 1, load while paused, then resume
    tick("pause");
    chk("pause.state", 4'(state_out), 4'd2);
    for (int i = 0; i < 4; i++) begin
      tick("pause");
      chk("pause.enable", 4'(enable), 4'd0);
    end
    chk("pause.updown", 4'(updown), 4'd1);
    sw_value = 4'h5;
    press_load("pause_ld");
    tick("pause_ld");
    chk("pause_ld.load", 4'(load), 4'd1);
    chk("pause_ld.state", 4'(state_out), 4'd2);
    tick("pause_ld");
    chk("pause_ld.load_off", 4'(load), 4'd0);
    sw_bounce = 1'b1;
    press_start("resume");
    tick("resume");
    chk("resume.state", 4'(state_out), 4'd1);
    for (int i = 1; i <= 3; i++) begin
      tick("resume");
      chk("resume.enable", 4'(enable), 4'(i == 3));
    end

    // Bounce at the limit: direction flips together with the step
    for (int i = 0; i < 3; i++) tick("bounce");
    done = 1'b1;
    tick("bounce");
    chk("bounce.enable", 4'(enable), 4'd1);
    chk("bounce.updown", 4'(updown), 4'd0);
    chk("bounce.state", 4'(state_out), 4'd1);
    done = 1'b0;

    // Halt at the limit; start ignored, load returns to idle
    sw_bounce = 1'b0;
    for (int i = 0; i < 3; i++) tick("halt");
    done = 1'b1;
    tick("halt");
    chk("halt.enable", 4'(enable), 4'd0);
    chk("halt.state", 4'(state_out), 4'd3);
    done = 1'b0;
    press_start("halt_st");
    tick("halt_st");
    tick("halt_st");
    chk("halt_st.state", 4'(state_out), 4'd3);
    press_load("halt_ld");
    tick("halt_ld");
    chk("halt_ld.load", 4'(load), 4'd1);
    tick("halt_ld");
    chk("halt_ld.load_off", 4'(load), 4'd0);
    chk("halt_ld.state", 4'(state_out), 4'd0);

    // Reset while a step pulse is high
    sw_dir = 1'b0; sw_mode = 1'b1;
    press_start("rstrun");
    tick("rstrun");
    for (int i = 0; i < 4; i++) tick("rstrun");
    chk("rstrun.enable", 4'(enable), 4'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rstmid.enable", 4'(enable), 4'd0);
    chk("rstmid.load", 4'(load), 4'd0);
    chk("rstmid.updown", 4'(updown), 4'd1);
    chk("rstmid.mode", 4'(mode), 4'd0);
    chk("rstmid.state", 4'(state_out), 4'd0);
    #3 reset = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 9) == 0) btn_load = ~btn_load;
      if ($urandom_range(0, 15) == 0) sw_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sw_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sw_bounce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sw_value = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 2) == 0);
      tick("rand");
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
